// File: rtl/noc_traffic_node_if.sv
`default_nettype none
// ============================================================================
// Module      : noc_traffic_if
// Description : Router local-port bundle (send and receive flit channels with
//               per-VC valid/ready) seen by a NoC traffic node.
// Revision    : 1.0
// ============================================================================
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

interface noc_traffic_if #(
    parameter int VC_NUM = 2
) ();
    logic [VC_NUM-1:0]          receive_valid;
    logic [VC_NUM-1:0]          receive_ready;
    logic [`Noc_Data_Width-1:0] receive_flit;
    logic                       receive_is_header;
    logic                       receive_is_tail;
    logic [VC_NUM-1:0]          sender_valid;
    logic [VC_NUM-1:0]          sender_ready;
    logic [`Noc_Data_Width-1:0] sender_flit;
    logic                       sender_is_header;
    logic                       sender_is_tail;

    modport master (
        input  receive_valid, receive_flit, receive_is_header, receive_is_tail, sender_ready,
        output receive_ready, sender_valid, sender_flit, sender_is_header, sender_is_tail
    );

    modport slave (
        output receive_valid, receive_flit, receive_is_header, receive_is_tail, sender_ready,
        input  receive_ready, sender_valid, sender_flit, sender_is_header, sender_is_tail
    );
endinterface
`default_nettype wire

// File: rtl/noc_traffic_node.sv
`default_nettype none
// ============================================================================
// Module      : noc_traffic_node
// Description : NoC endpoint traffic generator/checker. Macro
//               NOC_TRAFFIC_BACKPRESSURE_EN enables LFSR receive backpressure.
//               Noc_* sizing macros fall back to local defaults if undefined.
// Revision    : 1.0
// ============================================================================
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif
`ifndef Noc_Dest_Point
`define Noc_Dest_Point 0
`endif
`ifndef Noc_Source_Point
`define Noc_Source_Point 8
`endif
`ifndef Noc_Point_H
`define Noc_Point_H 16
`endif
`ifndef Noc_Head_Type
`define Noc_Head_Type 8'h48
`endif
`ifndef Noc_Tail_Type
`define Noc_Tail_Type 8'h54
`endif

module noc_traffic_node #(
    parameter int X_ID         = 0,
    parameter int Y_ID         = 0,
    parameter int DEST_X_ID    = 0,
    parameter int DEST_Y_ID    = 0,
    parameter int PKT_BODY_LEN = 11,
    parameter int PKT_NUM      = 11,
    parameter int VC_NUM       = 2,
    parameter int GAP_CYCLES   = 0
) (
    input  wire logic     noc_clk,
    input  wire logic     noc_rst_n,
    input  wire logic     start,
    noc_traffic_if.master noc,
    output logic          send_done,
    output logic [15:0]   receive_num,
    output logic [15:0]   err_num
);
    localparam int c_DW    = `Noc_Data_Width;
    localparam int c_VCW   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int c_SRC_W = `Noc_ID_X_Width + `Noc_ID_Y_Width;
    localparam logic [c_SRC_W-1:0] c_SRC = {X_ID[`Noc_ID_X_Width-1:0], Y_ID[`Noc_ID_Y_Width-1:0]};
    localparam logic [c_SRC_W-1:0] c_DST = {DEST_X_ID[`Noc_ID_X_Width-1:0], DEST_Y_ID[`Noc_ID_Y_Width-1:0]};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_BODY   = 3'd2,
        S_TAIL   = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic logic [c_DW-1:0] frame(input logic [7:0] kind);
        logic [c_DW-1:0] f;
        f = '0;
        f[c_DW-1 -: 8] = kind;
        f[`Noc_Point_H-1:`Noc_Source_Point] = c_SRC;
        f[`Noc_Source_Point-1:`Noc_Dest_Point] = c_DST;
        return f;
    endfunction

    function automatic logic [c_DW-1:0] body(input logic [15:0] pkt, input logic [7:0] beat);
        logic [c_DW-1:0] f;
        f = '1;
        f[23:0] = {pkt, beat};
        return f;
    endfunction

    // ---------------------------------------------------------------- sender
    state_t            r_state, w_state;
    logic [15:0]       r_pkt, w_pkt;
    logic [7:0]        r_beat, w_beat, r_gap, w_gap;
    logic [c_VCW-1:0]  r_vc, w_vc, w_vc_inc;
    logic [VC_NUM-1:0] r_valid, w_valid;
    logic [c_DW-1:0]   r_flit, w_flit;
    logic              r_hdr, w_hdr, r_tail, w_tail, r_done, w_done;
    logic              w_xfer, w_last, w_adv, w_fin;

    assign w_xfer   = |(r_valid & noc.sender_ready);
    assign w_last   = (r_pkt == 16'(PKT_NUM - 1));
    assign w_vc_inc = (r_vc == c_VCW'(VC_NUM - 1)) ? '0 : r_vc + c_VCW'(1);

    always_comb begin
        w_state = r_state;
        w_pkt   = r_pkt;
        w_beat  = r_beat;
        w_gap   = r_gap;
        w_vc    = r_vc;
        w_valid = r_valid;
        w_flit  = r_flit;
        w_hdr   = r_hdr;
        w_tail  = r_tail;
        w_done  = r_done;
        w_adv   = 1'b0;
        w_fin   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state = S_HEADER;
                    w_pkt   = '0;
                    w_beat  = '0;
                    w_vc    = '0;
                    w_valid = VC_NUM'(1);
                    w_flit  = frame(`Noc_Head_Type);
                    w_hdr   = 1'b1;
                    w_tail  = 1'b0;
                    w_done  = 1'b0;
                end
            end
            S_HEADER: begin
                if (w_xfer) begin
                    w_hdr  = 1'b0;
                    w_beat = '0;
                    if (PKT_BODY_LEN == 0) begin
                        w_state = S_TAIL;
                        w_tail  = 1'b1;
                        w_flit  = frame(`Noc_Tail_Type);
                    end else begin
                        w_state = S_BODY;
                        w_flit  = body(r_pkt, 8'd0);
                    end
                end
            end
            S_BODY: begin
                if (w_xfer) begin
                    if (r_beat == 8'(PKT_BODY_LEN - 1)) begin
                        w_state = S_TAIL;
                        w_tail  = 1'b1;
                        w_flit  = frame(`Noc_Tail_Type);
                    end else begin
                        w_beat = r_beat + 8'd1;
                        w_flit = body(r_pkt, r_beat + 8'd1);
                    end
                end
            end
            S_TAIL: begin
                if (w_xfer) begin
                    w_tail = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        w_state = S_GAP;
                        w_gap   = '0;
                        w_valid = '0;
                    end else begin
                        w_fin = w_last;
                        w_adv = !w_last;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == 8'(GAP_CYCLES - 1)) begin
                    w_fin = w_last;
                    w_adv = !w_last;
                end else begin
                    w_gap = r_gap + 8'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (w_fin) begin
            w_state = S_DONE;
            w_valid = '0;
            w_done  = 1'b1;
        end
        // Next packet rotates to the following VC and re-raises valid at once.
        if (w_adv) begin
            w_state = S_HEADER;
            w_pkt   = r_pkt + 16'd1;
            w_vc    = w_vc_inc;
            w_valid = VC_NUM'(1) << w_vc_inc;
            w_flit  = frame(`Noc_Head_Type);
            w_hdr   = 1'b1;
            w_tail  = 1'b0;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_state <= S_IDLE;
            r_pkt   <= '0;
            r_beat  <= '0;
            r_gap   <= '0;
            r_vc    <= '0;
            r_valid <= '0;
            r_flit  <= '0;
            r_hdr   <= 1'b0;
            r_tail  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pkt   <= w_pkt;
            r_beat  <= w_beat;
            r_gap   <= w_gap;
            r_vc    <= w_vc;
            r_valid <= w_valid;
            r_flit  <= w_flit;
            r_hdr   <= w_hdr;
            r_tail  <= w_tail;
            r_done  <= w_done;
        end
    end

    assign noc.sender_valid     = r_valid;
    assign noc.sender_flit      = r_flit;
    assign noc.sender_is_header = r_hdr;
    assign noc.sender_is_tail   = r_tail;
    assign send_done            = r_done;

    // --------------------------------------------------------------- checker
    logic [VC_NUM-1:0] r_rdy, w_acc, w_good, w_err;
    logic              w_multi, w_err_any;

    assign w_multi   = (noc.receive_valid & (noc.receive_valid - VC_NUM'(1))) != '0;
    assign w_acc     = w_multi ? '0 : (noc.receive_valid & r_rdy);
    assign w_err_any = (|w_err) | w_multi;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic               r_in_pkt, w_in_pkt, w_good_v, w_err_v;
        logic [7:0]         r_cnt, w_cnt;
        logic [c_SRC_W-1:0] r_src, w_src;

        always_comb begin
            w_in_pkt = r_in_pkt;
            w_cnt    = r_cnt;
            w_src    = r_src;
            w_good_v = 1'b0;
            w_err_v  = 1'b0;
            if (w_acc[v]) begin
                if (noc.receive_is_header) begin
                    w_err_v  = r_in_pkt;
                    w_in_pkt = 1'b1;
                    w_cnt    = '0;
                    w_src    = noc.receive_flit[`Noc_Point_H-1:`Noc_Source_Point];
                end else if (!r_in_pkt) begin
                    w_err_v = 1'b1;
                end else if (noc.receive_is_tail) begin
                    w_in_pkt = 1'b0;
                    w_good_v = (r_cnt == 8'(PKT_BODY_LEN));
                    w_err_v  = (r_cnt != 8'(PKT_BODY_LEN));
                end else begin
                    w_cnt   = r_cnt + 8'd1;
                    w_err_v = (noc.receive_flit[7:0] != r_cnt);
                end
            end
        end

        always_ff @(posedge noc_clk or negedge noc_rst_n) begin
            if (!noc_rst_n) begin
                r_in_pkt <= 1'b0;
                r_cnt    <= '0;
                r_src    <= '0;
            end else begin
                r_in_pkt <= w_in_pkt;
                r_cnt    <= w_cnt;
                r_src    <= w_src;
            end
        end

        assign w_good[v] = w_good_v;
        assign w_err[v]  = w_err_v;
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            receive_num <= '0;
            err_num     <= '0;
        end else begin
            if ((|w_good) && (receive_num != 16'hFFFF)) receive_num <= receive_num + 16'd1;
            if (w_err_any && (err_num != 16'hFFFF))     err_num     <= err_num + 16'd1;
        end
    end

`ifdef NOC_TRAFFIC_BACKPRESSURE_EN
    localparam logic [7:0] c_SEED = 8'hA5 ^ 8'(c_SRC);
    logic [7:0] r_lfsr, w_lfsr;

    assign w_lfsr = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_lfsr <= c_SEED;
            r_rdy  <= '0;
        end else begin
            r_lfsr <= w_lfsr;
            r_rdy  <= w_lfsr[VC_NUM-1:0];
        end
    end
`else
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) r_rdy <= '0;
        else            r_rdy <= '1;
    end
`endif

    assign noc.receive_ready = r_rdy;
endmodule
`default_nettype wire

// File: tb/tb_noc_traffic_node.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_traffic_node
// Description : Directed bench for noc_traffic_node with a sent-flit scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_noc_traffic_node;
    localparam int VC_NUM       = 2;
    localparam int PKT_NUM      = 3;
    localparam int PKT_BODY_LEN = 4;

    logic        noc_clk = 1'b0;
    logic        noc_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        send_done;
    logic [15:0] receive_num, err_num;

    logic        loop = 1'b1;
    logic [1:0]  snd_ready = 2'b11;
    logic [1:0]  inj_valid = 2'b00;
    logic [31:0] inj_flit = '0;
    logic        inj_hdr = 1'b0, inj_tail = 1'b0;

    int unsigned checks = 0, errors = 0;
    logic [35:0] exp_q[$];

    noc_traffic_if #(.VC_NUM(VC_NUM)) nif ();

    assign nif.sender_ready      = snd_ready;
    assign nif.receive_valid     = loop ? (nif.sender_valid & nif.sender_ready) : inj_valid;
    assign nif.receive_flit      = loop ? nif.sender_flit      : inj_flit;
    assign nif.receive_is_header = loop ? nif.sender_is_header : inj_hdr;
    assign nif.receive_is_tail   = loop ? nif.sender_is_tail   : inj_tail;

    noc_traffic_node #(
        .X_ID(1), .Y_ID(2), .DEST_X_ID(3), .DEST_Y_ID(4),
        .PKT_BODY_LEN(PKT_BODY_LEN), .PKT_NUM(PKT_NUM), .VC_NUM(VC_NUM), .GAP_CYCLES(0)
    ) dut (
        .noc_clk(noc_clk),
        .noc_rst_n(noc_rst_n),
        .start(start),
        .noc(nif),
        .send_done(send_done),
        .receive_num(receive_num),
        .err_num(err_num)
    );

    always #5 noc_clk = ~noc_clk;

    localparam logic [31:0] HDR  = {8'h48, 8'h00, 8'h12, 8'h34};
    localparam logic [31:0] TAIL = {8'h54, 8'h00, 8'h12, 8'h34};

    function automatic logic [31:0] bodyf(input int p, input int k);
        return {8'hFF, 16'(p), 8'(k)};
    endfunction

    // {valid, is_header, is_tail, flit} for flit i of packet p
    function automatic logic [35:0] exp_flit(input int p, input int i);
        logic [31:0] f;
        logic        h, t;
        h = (i == 0);
        t = (i == PKT_BODY_LEN + 1);
        f = h ? HDR : (t ? TAIL : bodyf(p, i - 1));
        return {2'(1 << (p % VC_NUM)), h, t, f};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] snd_obs();
        return {nif.sender_valid, nif.sender_is_header, nif.sender_is_tail, nif.sender_flit};
    endfunction

    task automatic run_traffic(input int stall_after, input int stall_len);
        int          nflit = 0, cyc = 0, left = stall_len, first = -1, last = -1;
        logic        stalled = 1'b0;
        logic [35:0] e;
        for (int p = 0; p < PKT_NUM; p++)
            for (int i = 0; i < PKT_BODY_LEN + 2; i++) exp_q.push_back(exp_flit(p, i));
        @(negedge noc_clk);
        start = 1'b1;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge noc_clk);
            cyc++;
            start = 1'b0;
            if (nflit == stall_after && left > 0) begin
                snd_ready = 2'b10;
                stalled   = 1'b1;
                left--;
            end else begin
                snd_ready = 2'b11;
                stalled   = 1'b0;
            end
            #1;
            if (stalled) begin
                chk("stall_hold", snd_obs(), exp_q[0]);
            end else if (|(nif.sender_valid & snd_ready)) begin
                e = exp_q.pop_front();
                chk("flit", snd_obs(), e);
                nflit++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        chk("flits_left", exp_q.size(), 0);
        exp_q.delete();
        if (stall_len == 0) chk("burst_cycles", last - first + 1, 18);
        repeat (2) @(negedge noc_clk);
    endtask

    task automatic inject(input logic [1:0] v, input logic h, input logic t, input logic [31:0] f);
        @(negedge noc_clk);
        inj_valid = v;
        inj_hdr   = h;
        inj_tail  = t;
        inj_flit  = f;
        @(negedge noc_clk);
        inj_valid = 2'b00;
        inj_hdr   = 1'b0;
        inj_tail  = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge noc_clk);
        chk("rst_valid", nif.sender_valid, 2'b00);
        chk("rst_ready", nif.receive_ready, 2'b00);
        chk("rst_done", send_done, 1'b0);
        chk("rst_rx", receive_num, 16'd0);
        chk("rst_err", err_num, 16'd0);
        noc_rst_n = 1'b1;
        @(negedge noc_clk);
        chk("ready_after_rst", nif.receive_ready, 2'b11);
        chk("idle_valid", nif.sender_valid, 2'b00);

        // T1 loopback
        run_traffic(-1, 0);
        chk("t1_done", send_done, 1'b1);
        chk("t1_rx", receive_num, 16'd3);
        chk("t1_err", err_num, 16'd0);

        // T2 stall VC0 mid-body for 5 cycles
        run_traffic(3, 5);
        chk("t2_done", send_done, 1'b1);
        chk("t2_rx", receive_num, 16'd6);
        chk("t2_err", err_num, 16'd0);

        // T3 orphan body on VC1, then a legal packet
        loop = 1'b0;
        inject(2'b10, 1'b0, 1'b0, bodyf(0, 0));
        chk("t3_err", err_num, 16'd1);
        chk("t3_rx_same", receive_num, 16'd6);
        inject(2'b10, 1'b1, 1'b0, HDR);
        for (int k = 0; k < PKT_BODY_LEN; k++) inject(2'b10, 1'b0, 1'b0, bodyf(0, k));
        inject(2'b10, 1'b0, 1'b1, TAIL);
        chk("t3_rx", receive_num, 16'd7);
        chk("t3_err_after", err_num, 16'd1);

        // T4 short packet
        inject(2'b01, 1'b1, 1'b0, HDR);
        for (int k = 0; k < 3; k++) inject(2'b01, 1'b0, 1'b0, bodyf(0, k));
        inject(2'b01, 1'b0, 1'b1, TAIL);
        chk("t4_err", err_num, 16'd2);
        chk("t4_rx", receive_num, 16'd7);

        // T5 multi-hot valid must not disturb either VC
        inject(2'b01, 1'b1, 1'b0, HDR);
        inject(2'b01, 1'b0, 1'b0, bodyf(0, 0));
        inject(2'b01, 1'b0, 1'b0, bodyf(0, 1));
        inject(2'b11, 1'b1, 1'b0, HDR);
        chk("t5_err", err_num, 16'd3);
        inject(2'b01, 1'b0, 1'b0, bodyf(0, 2));
        inject(2'b01, 1'b0, 1'b0, bodyf(0, 3));
        inject(2'b01, 1'b0, 1'b1, TAIL);
        chk("t5_vc0_rx", receive_num, 16'd8);
        chk("t5_vc0_err", err_num, 16'd3);
        inject(2'b10, 1'b0, 1'b0, bodyf(0, 0));
        chk("t5_vc1_idle", err_num, 16'd4);

        // T6 reset during BODY, then restart
        loop = 1'b1;
        @(negedge noc_clk);
        start = 1'b1;
        @(negedge noc_clk);
        start = 1'b0;
        repeat (3) @(negedge noc_clk);
        chk("t6_mid_body", snd_obs(), exp_flit(0, 3));
        #1 noc_rst_n = 1'b0;
        #1;
        chk("t6_rst_snd", {snd_obs(), send_done}, 37'd0);
        chk("t6_rst_cnt", {receive_num, err_num}, 32'd0);
        @(negedge noc_clk);
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        run_traffic(-1, 0);
        chk("t6_rx", receive_num, 16'd3);
        chk("t6_err", err_num, 16'd0);
        chk("t6_done", send_done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
